// File: rtl/alu_addsub_stage_if.sv
// alu_addsub_stage_if: upstream, downstream and adder signals of the add/sub execute stage
interface alu_addsub_stage_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_s;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_wen;
    logic [3:0]       out_flags;
    logic             carry_flag;

    modport slave (
        input  in_valid, in_op, in_a, in_b, add_s, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_result, out_wen, out_flags, carry_flag
    );

    modport master (
        output in_valid, in_op, in_a, in_b, add_s, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_result, out_wen, out_flags, carry_flag
    );
endinterface

// File: rtl/alu_addsub_stage.sv
// alu_addsub_stage: two-stage add/sub execute stage driving an external carry-lookahead adder
module alu_addsub_stage #(
    parameter int WIDTH = 32
) (
    input logic                clk,
    input logic                rst_n,
    alu_addsub_stage_if.slave  bus
);
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ADDC = 2'b10, OP_CMP = 2'b11} op_e;

    logic             valid_a_q, valid_a_d;
    op_e              op_a_q, op_a_d;
    logic [WIDTH-1:0] a_a_q, a_a_d;
    logic [WIDTH-1:0] b_a_q, b_a_d;
    logic             valid_b_q, valid_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             wen_q, wen_d;
    logic [3:0]       flags_q, flags_d;
    logic             carry_q, carry_d;

    logic             advance_b, advance_a, accept, sub_w;
    logic [WIDTH-1:0] add_b_w;
    logic [3:0]       flags_w;

    assign advance_b = !valid_b_q || bus.out_ready;
    assign advance_a = valid_a_q && advance_b;
    assign accept    = bus.in_valid && bus.in_ready;
    assign sub_w     = op_a_q == OP_SUB || op_a_q == OP_CMP;

    // Idle stage A parks the adder b/cin at zero so it does not toggle
    assign add_b_w     = !valid_a_q ? '0 : sub_w ? ~b_a_q : b_a_q;
    assign bus.add_a   = a_a_q;
    assign bus.add_b   = add_b_w;
    assign bus.add_cin = valid_a_q && (sub_w || (op_a_q == OP_ADDC && carry_q));

    assign flags_w = {bus.add_s[WIDTH-1],
                      bus.add_s == '0,
                      bus.add_cout,
                      (a_a_q[WIDTH-1] == add_b_w[WIDTH-1]) && (bus.add_s[WIDTH-1] != a_a_q[WIDTH-1])};

    assign bus.in_ready   = !valid_a_q || advance_b;
    assign bus.out_valid  = valid_b_q;
    assign bus.out_result = result_q;
    assign bus.out_wen    = wen_q;
    assign bus.out_flags  = flags_q;
    assign bus.carry_flag = carry_q;

    // Next state: load A on accept, move A into B (and latch carry) when B can take it
    always_comb begin
        valid_a_d = accept ? 1'b1 : advance_a ? 1'b0 : valid_a_q;
        op_a_d    = accept ? op_e'(bus.in_op) : op_a_q;
        a_a_d     = accept ? bus.in_a : a_a_q;
        b_a_d     = accept ? bus.in_b : b_a_q;
        valid_b_d = advance_b ? valid_a_q : valid_b_q;
        result_d  = advance_a ? bus.add_s : result_q;
        wen_d     = advance_a ? op_a_q != OP_CMP : wen_q;
        flags_d   = advance_a ? flags_w : flags_q;
        carry_d   = advance_a ? bus.add_cout : carry_q;
    end

    // Pipeline registers; reset discards any in-flight operations
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_a_q <= 1'b0;
            op_a_q    <= OP_ADD;
            a_a_q     <= '0;
            b_a_q     <= '0;
            valid_b_q <= 1'b0;
            result_q  <= '0;
            wen_q     <= 1'b0;
            flags_q   <= '0;
            carry_q   <= 1'b0;
        end else begin
            valid_a_q <= valid_a_d;
            op_a_q    <= op_a_d;
            a_a_q     <= a_a_d;
            b_a_q     <= b_a_d;
            valid_b_q <= valid_b_d;
            result_q  <= result_d;
            wen_q     <= wen_d;
            flags_q   <= flags_d;
            carry_q   <= carry_d;
        end
    end
endmodule

// File: doc/alu_addsub_stage.md
# alu_addsub_stage

Two-stage pipelined add/subtract execute stage for the KGP mini-RISC datapath, wrapped around the 32-bit carry-lookahead adder. It accepts ALU operations over a valid/ready handshake and registers them. It drives the adder's a/b/cin inputs from the operand register and captures the adder's sum/carry into a result register with N/Z/C/V flags. It holds an architectural carry flag for add-with-carry.

## Interface
Parameters:
- WIDTH, 32, datapath width; must equal the width of the attached carry-lookahead adder.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream operation valid.
- in_ready  out  1  stage can accept an operation this cycle.
- in_op  in  2  00 ADD, 01 SUB, 10 ADDC, 11 CMP.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- add_a  out  WIDTH  to adder a.
- add_b  out  WIDTH  to adder b.
- add_cin  out  1  to adder cin.
- add_s  in  WIDTH  from adder sum; combinational function of add_a/add_b/add_cin.
- add_cout  in  1  from adder carry out.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_result  out  WIDTH  registered sum.
- out_wen  out  1  result is to be written back; 0 for CMP.
- out_flags  out  4  {N,Z,C,V} of this result.
- carry_flag  out  1  architectural carry flag.

## Operation
- Stage A holds the operand register: valid_a, op_a, a_a, b_a. Stage B holds the result register: valid_b, result, wen, flags.
- Adder drive from stage A:
  - add_a = a_a.
  - ADD: add_b = b_a, add_cin = 0.
  - SUB and CMP: add_b = ~b_a, add_cin = 1.
  - ADDC: add_b = b_a, add_cin = carry_flag.
  - When valid_a = 0, drive add_b = 0 and add_cin = 0 to reduce toggling.
- Flags captured into stage B:
  - N = add_s[WIDTH-1].
  - Z = (add_s == 0).
  - C = add_cout. For SUB/CMP, C = 1 means no borrow.
  - V = (a_a[MSB] == add_b[MSB]) && (add_s[MSB] != a_a[MSB]).
- out_wen = 1 for ADD/SUB/ADDC and 0 for CMP. CMP still produces a result and flags.
- carry_flag is loaded with add_cout on the same edge that stage A moves into stage B. Every op type, including CMP, updates it.
- Consequence: an ADDC in stage A always sees the carry of the op immediately before it, so no forwarding or hazard logic is required.
- Handshake control:
  - advance_b = !valid_b || out_ready.
  - advance_a = valid_a && advance_b.
  - in_ready = !valid_a || advance_b.
  - Accept occurs when in_valid && in_ready.
- Stall: while out_valid && !out_ready, stage B holds out_result, out_flags and out_wen stable. Stage A also holds if it is occupied.
- On rst_n low, immediately and regardless of clk:
  - valid_a, valid_b, carry_flag and all registers go to 0.
  - out_valid = 0, out_result = 0, out_flags = 0, out_wen = 0.
  - in_ready = 1 once valid_a = 0.
  - In-flight operations are discarded, not replayed.

## Timing
- Latency: an op accepted at edge t is in stage A during cycle t+1. It is captured into stage B at edge t+1. out_valid is high from cycle t+2.
- Throughput is 1 op/cycle while out_ready = 1.
- The adder path is combinational within one cycle: stage A register → adder → stage B register.
- Simultaneous accept and advance on one edge: stage A moves to B and the new op loads into A on the same edge.
- Full: valid_a && valid_b && !out_ready → in_ready = 0.
- Empty: no output until an accept. out_valid deasserts the cycle after its handshake if stage A is empty.
- Reset deassertion is synchronised externally. The first accept can occur on the first rising edge with rst_n high.

## Test plan
- ADD 0x0000_0005 + 0x0000_0003, out_ready = 1 → out_valid 2 cycles after accept; result 0x0000_0008, flags N0 Z0 C0 V0, wen 1, carry_flag 0.
- SUB 0x0000_0003 − 0x0000_0005 → result 0xFFFF_FFFE, N1 Z0 C0 V0. CMP 0x8000_0000 vs 0x0000_0001 → result 0x7FFF_FFFF, V1 C1, wen 0.
- Back-to-back ADD 0xFFFF_FFFF + 0x0000_0001, then ADDC 0x0000_0000 + 0x0000_0000 → first result 0, Z1 C1. Second result 0x0000_0001, because the carry is consumed without bubbles.
- Backpressure: issue 3 ops with out_ready held 0 → in_ready drops after 2 accepts. out_result and out_flags stay stable. Releasing out_ready drains results in order, one per cycle.
- ADD 0x7FFF_FFFF + 0x0000_0001 → result 0x8000_0000, N1 V1 C0.
- Assert rst_n low mid-stream with both stages full → out_valid, out_result, out_flags and carry_flag go 0 asynchronously. After release, the next op behaves as if it were the first op after reset.
